// File: rtl/spike_isi_receiver_pkg.sv
// Shared definitions for the spike ISI receiver.
//   ISI_W_DEF / DEPTH_DEF / CNT_W_DEF : default interval width, FIFO depth and
//                                       spike counter width
//   isi_event_t                       : one queued event {first, isi}
package izh_rx_pkg;

    localparam int ISI_W_DEF = 12;
    localparam int DEPTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef struct packed {
        logic                 first;
        logic [ISI_W_DEF-1:0] isi;
    } isi_event_t;

endpackage

// File: rtl/spike_isi_receiver_if.sv
// Readout handshake between the ISI receiver and the host-facing logic.
//   isi_valid : head entry present (receiver -> consumer)
//   isi_ready : consumer accepts the head entry (consumer -> receiver)
//   isi_data  : head entry interval in clock cycles
//   isi_first : head entry is the first spike since reset
interface spike_isi_receiver_if #(
    parameter int ISI_W = izh_rx_pkg::ISI_W_DEF
);
    logic             isi_valid;
    logic             isi_ready;
    logic [ISI_W-1:0] isi_data;
    logic             isi_first;

    modport master (output isi_valid, output isi_data, output isi_first, input isi_ready);
    modport slave  (input isi_valid, input isi_data, input isi_first, output isi_ready);
endinterface

// File: rtl/spike_event_fifo.sv
// First-word-fall-through event FIFO.
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write request and entry
//   pop             : remove head entry (ignored when empty)
//   head            : current head entry, zero while empty
//   full, empty     : occupancy flags
// A push on a full FIFO succeeds when a pop happens in the same cycle: the
// freed slot is the one being written.
module spike_event_fifo
    import izh_rx_pkg::*;
#(
    parameter int  DEPTH = DEPTH_DEF,
    parameter type T     = isi_event_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    T              mem_q [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [AW:0]   cnt_q;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = empty ? T'('0) : mem_q[rd_q];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/spike_isi_receiver.sv
// Spike inter-spike-interval receiver.
//   clk, rst     : clock, synchronous active-high reset
//   ena          : capture enable; low freezes the interval counter and capture
//   spike_in     : spike level from the neuron core
//   clear_stats  : pulse clearing spike_count and overflow
//   isi_if       : readout handshake (master side)
//   spike_count  : accepted spikes, saturating
//   overflow     : sticky, an event was dropped on a full FIFO
module spike_isi_receiver
    import izh_rx_pkg::*;
#(
    parameter int ISI_W = ISI_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 spike_in,
    input  logic                 clear_stats,
    spike_isi_receiver_if.master isi_if,
    output logic [CNT_W-1:0]     spike_count,
    output logic                 overflow
);

    typedef struct packed {
        logic             first;
        logic [ISI_W-1:0] isi;
    } evt_t;

    localparam logic [ISI_W-1:0] ISI_MAX = {ISI_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             prev_q;
    logic [ISI_W-1:0] ctr_q,   ctr_d;
    logic             first_pending_q, first_pending_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             ovf_q,   ovf_d;

    logic spike_edge;
    logic pop;
    logic drop;
    logic fifo_full;
    logic fifo_empty;
    evt_t push_evt;
    evt_t head_evt;

    assign spike_edge = spike_in & ~prev_q & ena;
    assign pop        = ~fifo_empty & isi_if.isi_ready;
    assign drop       = spike_edge & fifo_full & ~pop;
    assign push_evt   = '{first: first_pending_q, isi: ctr_q};

    always_comb begin
        ctr_d           = ctr_q;
        first_pending_d = first_pending_q;
        cnt_d           = cnt_q;
        ovf_d           = ovf_q;

        if (ena) begin
            if (spike_edge) begin
                ctr_d = ISI_W'(1);
            end else if (ctr_q != ISI_MAX) begin
                ctr_d = ctr_q + 1'b1;
            end
        end

        // A dropped first event still consumes the "first" marker.
        if (spike_edge) begin
            first_pending_d = 1'b0;
        end

        if (clear_stats) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (spike_edge && cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    // prev resets high so a level already high at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q          <= 1'b1;
            ctr_q           <= '0;
            first_pending_q <= 1'b1;
            cnt_q           <= '0;
            ovf_q           <= 1'b0;
        end else begin
            prev_q          <= spike_in;
            ctr_q           <= ctr_d;
            first_pending_q <= first_pending_d;
            cnt_q           <= cnt_d;
            ovf_q           <= ovf_d;
        end
    end

    spike_event_fifo #(
        .DEPTH (DEPTH),
        .T     (evt_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (spike_edge),
        .push_data (push_evt),
        .pop       (pop),
        .head      (head_evt),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign isi_if.isi_valid = ~fifo_empty;
    assign isi_if.isi_data  = head_evt.isi;
    assign isi_if.isi_first = head_evt.first;
    assign spike_count      = cnt_q;
    assign overflow         = ovf_q;

endmodule

// File: tb/tb_spike_isi_receiver.sv
// Directed bench for spike_isi_receiver. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_spike_isi_receiver;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       spike_in;
    logic       clear_stats;
    logic [7:0] spike_count;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    spike_isi_receiver_if #(.ISI_W(12)) isi_if ();

    spike_isi_receiver dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .spike_in    (spike_in),
        .clear_stats (clear_stats),
        .isi_if      (isi_if),
        .spike_count (spike_count),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        spike_in = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic fire();
        spike_in = 1'b1;
        @(negedge clk);
        spike_in = 1'b0;
    endtask

    task automatic do_reset(input bit hold_high);
        rst              = 1'b1;
        spike_in         = hold_high;
        ena              = 1'b1;
        clear_stats      = 1'b0;
        isi_if.isi_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        checks++; if (isi_if.isi_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", isi_if.isi_valid); end
        checks++; if (isi_if.isi_data !== 12'd0) begin errors++; $display("FAIL reset_data got %0d exp 0", isi_if.isi_data); end
        checks++; if (isi_if.isi_first !== 1'b0) begin errors++; $display("FAIL reset_first got %b exp 0", isi_if.isi_first); end
        checks++; if (spike_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", spike_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    endtask

    task automatic test_basic();
        isi_if.isi_ready = 1'b1;
        idle(10);
        fire();
        checks++; if (isi_if.isi_valid !== 1'b1) begin errors++; $display("FAIL basic_valid1 got %b exp 1", isi_if.isi_valid); end
        checks++; if (isi_if.isi_data !== 12'd10) begin errors++; $display("FAIL basic_isi1 got %0d exp 10", isi_if.isi_data); end
        checks++; if (isi_if.isi_first !== 1'b1) begin errors++; $display("FAIL basic_first1 got %b exp 1", isi_if.isi_first); end
        checks++; if (spike_count !== 8'd1) begin errors++; $display("FAIL basic_count1 got %0d exp 1", spike_count); end
        idle(14);
        fire();
        checks++; if (isi_if.isi_data !== 12'd15) begin errors++; $display("FAIL basic_isi2 got %0d exp 15", isi_if.isi_data); end
        checks++; if (isi_if.isi_first !== 1'b0) begin errors++; $display("FAIL basic_first2 got %b exp 0", isi_if.isi_first); end
        checks++; if (spike_count !== 8'd2) begin errors++; $display("FAIL basic_count2 got %0d exp 2", spike_count); end
        idle(1);
        checks++; if (isi_if.isi_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got %b exp 0", isi_if.isi_valid); end
    endtask

    task automatic test_saturate();
        idle(4999);
        fire();
        checks++; if (isi_if.isi_data !== 12'd4095) begin errors++; $display("FAIL sat_isi got %0d exp 4095", isi_if.isi_data); end
        checks++; if (spike_count !== 8'd3) begin errors++; $display("FAIL sat_count got %0d exp 3", spike_count); end
        idle(1);
    endtask

    task automatic test_overflow();
        do_reset(1'b0);
        idle(10);
        fire();
        for (int i = 0; i < 4; i++) begin
            idle(9);
            fire();
        end
        checks++; if (spike_count !== 8'd5) begin errors++; $display("FAIL ovf_count got %0d exp 5", spike_count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        checks++; if (isi_if.isi_data !== 12'd10) begin errors++; $display("FAIL ovf_head_isi got %0d exp 10", isi_if.isi_data); end
        checks++; if (isi_if.isi_first !== 1'b1) begin errors++; $display("FAIL ovf_head_first got %b exp 1", isi_if.isi_first); end
    endtask

    task automatic test_pop_on_full();
        logic [11:0] exp_isi [4];
        exp_isi[0] = 12'd10; exp_isi[1] = 12'd10; exp_isi[2] = 12'd10; exp_isi[3] = 12'd7;
        clear_stats = 1'b1;
        @(negedge clk);
        clear_stats = 1'b0;
        checks++; if (spike_count !== 8'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", spike_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b exp 0", overflow); end
        idle(5);
        spike_in = 1'b1;
        isi_if.isi_ready = 1'b1;
        @(negedge clk);
        spike_in = 1'b0;
        isi_if.isi_ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL popfull_ovf got %b exp 0", overflow); end
        checks++; if (spike_count !== 8'd1) begin errors++; $display("FAIL popfull_count got %0d exp 1", spike_count); end
        isi_if.isi_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (isi_if.isi_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d] got %b exp 1", i, isi_if.isi_valid); end
            checks++; if (isi_if.isi_data !== exp_isi[i]) begin errors++; $display("FAIL drain_isi[%0d] got %0d exp %0d", i, isi_if.isi_data, exp_isi[i]); end
            checks++; if (isi_if.isi_first !== 1'b0) begin errors++; $display("FAIL drain_first[%0d] got %b exp 0", i, isi_if.isi_first); end
            @(negedge clk);
        end
        checks++; if (isi_if.isi_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b exp 0", isi_if.isi_valid); end
        isi_if.isi_ready = 1'b0;
    endtask

    task automatic test_held_high();
        fire();
        checks++; if (isi_if.isi_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", isi_if.isi_valid); end
        do_reset(1'b1);
        checks++; if (isi_if.isi_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", isi_if.isi_valid); end
        checks++; if (spike_count !== 8'd0) begin errors++; $display("FAIL midreset_count got %0d exp 0", spike_count); end
        repeat (20) @(negedge clk);
        checks++; if (isi_if.isi_valid !== 1'b0) begin errors++; $display("FAIL held_valid got %b exp 0", isi_if.isi_valid); end
        checks++; if (spike_count !== 8'd0) begin errors++; $display("FAIL held_count got %0d exp 0", spike_count); end
        idle(3);
        fire();
        checks++; if (isi_if.isi_valid !== 1'b1) begin errors++; $display("FAIL held_ev_valid got %b exp 1", isi_if.isi_valid); end
        checks++; if (isi_if.isi_data !== 12'd23) begin errors++; $display("FAIL held_ev_isi got %0d exp 23", isi_if.isi_data); end
        checks++; if (isi_if.isi_first !== 1'b1) begin errors++; $display("FAIL held_ev_first got %b exp 1", isi_if.isi_first); end
        isi_if.isi_ready = 1'b1;
        idle(1);
    endtask

    task automatic test_ena_clear();
        idle(3);
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fire();
            idle(2);
        end
        checks++; if (isi_if.isi_valid !== 1'b0) begin errors++; $display("FAIL ena_valid got %b exp 0", isi_if.isi_valid); end
        checks++; if (spike_count !== 8'd1) begin errors++; $display("FAIL ena_count got %0d exp 1", spike_count); end
        ena = 1'b1;
        idle(5);
        fire();
        checks++; if (isi_if.isi_data !== 12'd10) begin errors++; $display("FAIL ena_frozen_isi got %0d exp 10", isi_if.isi_data); end
        checks++; if (spike_count !== 8'd2) begin errors++; $display("FAIL ena_count2 got %0d exp 2", spike_count); end
        idle(3);
        spike_in    = 1'b1;
        clear_stats = 1'b1;
        @(negedge clk);
        spike_in    = 1'b0;
        clear_stats = 1'b0;
        checks++; if (spike_count !== 8'd0) begin errors++; $display("FAIL clr_edge_count got %0d exp 0", spike_count); end
        checks++; if (isi_if.isi_valid !== 1'b1) begin errors++; $display("FAIL clr_edge_valid got %b exp 1", isi_if.isi_valid); end
        checks++; if (isi_if.isi_data !== 12'd4) begin errors++; $display("FAIL clr_edge_isi got %0d exp 4", isi_if.isi_data); end
        idle(1);
    endtask

    initial begin
        rst              = 1'b1;
        ena              = 1'b1;
        spike_in         = 1'b0;
        clear_stats      = 1'b0;
        isi_if.isi_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_saturate();
        test_overflow();
        test_pop_on_full();
        test_held_high();
        test_ena_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_isi_receiver.md
# spike_isi_receiver

Receiving end of the neuron spike output: samples the 1-bit spike line produced by the Izhikevich neuron core, detects rising edges and measures the inter-spike interval (ISI) in clock cycles. Each accepted spike is queued as an ISI event in a small first-word-fall-through FIFO drained by a valid/ready handshake. The block also keeps a saturating spike count and a sticky overflow flag. It sits between the neuron core's spike output and the host-facing readout logic of the tt_um system.

## Interface
Parameters:
- ISI_W, 12, ISI counter/data width; saturates at 2^ISI_W-1
- DEPTH, 4, FIFO entries (power of two, ≥2)
- CNT_W, 8, spike counter width; saturates at 2^CNT_W-1

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset; synchronous, active-high
- ena  in  1  capture enable; low freezes ISI counter and event capture
- spike_in  in  1  spike level from neuron core, same clock domain
- clear_stats  in  1  one-cycle pulse; clears spike_count and overflow
- isi_valid  out  1  FIFO non-empty
- isi_ready  in  1  consumer accepts head entry
- isi_data  out  ISI_W  head entry ISI in cycles
- isi_first  out  1  head entry is first spike since reset
- spike_count  out  CNT_W  accepted spikes, saturating
- overflow  out  1  sticky: an event was dropped on a full FIFO

## Operation
- Edge detect: prev <= spike_in every cycle (regardless of ena); edge = spike_in & ~prev & ena.
- ISI counter ctr: when ena, edge → ctr <= 1; else ctr <= min(ctr+1, max). ena low → ctr holds.
- So with edges at cycles t0, t1: captured ISI = t1-t0, saturating. First edge captures ctr as counted since reset release.
- Accepted edge pushes {first_pending, ctr}; first_pending set by reset, cleared on first accepted edge (even if that event is dropped).
- Push on full FIFO: event dropped, overflow <= 1, unless a pop occurs in the same cycle (then push succeeds, no overflow).
- Pop when isi_valid & isi_ready. Pop on empty is ignored.
- spike_count increments on every accepted edge, including dropped ones; saturates.
- clear_stats: spike_count <= 0, overflow <= 0; takes priority over a same-cycle increment/overflow. FIFO contents untouched.
- FIFO order strict FIFO; entries read out unchanged.

## Timing
- Reset values: isi_valid 0, isi_data 0, isi_first 0, spike_count 0, overflow 0; ctr 0, prev 1 (a level held high through reset is not an edge), first_pending 1, FIFO empty.
- Latency: spike_in first sampled high at edge k → entry written at edge k → isi_valid, isi_data, spike_count updated after edge k (one cycle from input change).
- isi_data/isi_first are valid whenever isi_valid=1 and stable until popped.
- isi_valid falls the cycle after popping the last entry; same-cycle push+pop on one-entry FIFO keeps isi_valid high.
- Reset mid-operation: all state returns to reset values next edge; pending entries lost.
- Minimum spike spacing: 2 cycles (high, low); each rising edge is one event.

## Structure
- Package izh_rx_pkg: default ISI_W/CNT_W/DEPTH constants, isi_event_t struct {first, isi}.
- Sub-module spike_event_fifo: parameterised FWFT FIFO (DEPTH, isi_event_t), push/pop/full/empty, simultaneous push/pop on full allowed.
- Top holds edge detector, ISI counter, counters/flags.

## Test plan
- Reset, ena=1, isi_ready=1, edges at cycles 10 and 25 after reset release → entries (first=1, isi=10), (first=0, isi=15); spike_count=2.
- Edges 5000 cycles apart, ISI_W=12 → second entry isi=4095.
- isi_ready=0, 5 edges 10 cycles apart → 4 entries, overflow=1, spike_count=5; drain yields isi 10,10,10,10 in order.
- FIFO full, edge coincident with pop → entry accepted, overflow stays 0, occupancy stays 4.
- spike_in held high across reset release for 20 cycles → no event; next low→high → one event, isi_first=1.
- ena=0 during 3 edges → no events, ctr frozen; clear_stats coincident with accepted edge → spike_count=0, entry still pushed.
